// File: rtl/p_mul_pkg.sv
// p_mul_pkg
// Shared definitions for the iterative packed-SIMD multiplier.
//   state_t     : FSM state encoding (IDLE / BUSY / DONE)
//   PW_IDX_*    : bit-index range of the one-hot pack-width select
//   pw_onehot   : true when the pack-width select has exactly one bit set
//   lane_width  : lane width W selected by a pack-width value (0 if invalid)
//   step_count  : number of BUSY steps needed for that lane width
package p_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // pw[PW_IDX_FULL] selects full-width lanes; each higher index halves the
  // lane. Pack-width values are handled zero-extended to PW_IDX_LIMIT bits.
  localparam int PW_IDX_FULL  = 0;
  localparam int PW_IDX_LIMIT = 32;

  function automatic logic pw_onehot(input logic [PW_IDX_LIMIT-1:0] pw);
    return (pw != '0) && ((pw & (pw - 32'd1)) == '0);
  endfunction

  function automatic int lane_width(input logic [PW_IDX_LIMIT-1:0] pw,
                                    input int xlen);
    int w;
    w = 0;
    if (pw_onehot(pw)) begin
      for (int i = PW_IDX_FULL; i < PW_IDX_LIMIT; i++) begin
        if (pw[i]) w = xlen >> i;
      end
    end
    return w;
  endfunction

  // ceil(W / bpc), with bpc restricted to 1, 2 or 4 so the divide is a shift.
  // An invalid pack width still takes one step so the handshake completes.
  function automatic int step_count(input logic [PW_IDX_LIMIT-1:0] pw,
                                    input int xlen, input int bpc);
    int w;
    int sh;
    w  = lane_width(pw, xlen);
    sh = (bpc >= 4) ? 2 : ((bpc >= 2) ? 1 : 0);
    if (w == 0) return 1;
    return (w + bpc - 1) >> sh;
  endfunction

endpackage

// File: rtl/p_mul_padd.sv
// p_mul_padd
// 2*XLEN-bit packed adder. The carry chain is broken at every lane-slice
// boundary (slice = 2W bits for the selected pack width), and in XOR mode
// no carries propagate at all, which gives carry-less accumulation.
// Ports:
//   pw       : one-hot pack width (an invalid value breaks at every bit)
//   xor_mode : 1 = bitwise XOR, 0 = lane-wise binary addition
//   a, b     : packed addends
//   sum      : packed result
module p_mul_padd
  import p_mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PW_W = $clog2(XLEN)
) (
  input  logic [PW_W-1:0]   pw,
  input  logic              xor_mode,
  input  logic [2*XLEN-1:0] a,
  input  logic [2*XLEN-1:0] b,
  output logic [2*XLEN-1:0] sum
);

  localparam int AW = 2 * XLEN;

  logic [AW-1:0] lane_start;

  // Mark the lowest bit of each 2W-bit accumulator slice.
  always_comb begin
    int slice;
    slice      = 2 * lane_width(32'(pw), XLEN);
    lane_start = '0;
    for (int i = 0; i < AW; i++) begin
      lane_start[i] = (slice == 0) || ((i & (slice - 1)) == 0);
    end
  end

  // Ripple carry; a new slice always starts with carry-in zero.
  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < AW; i++) begin
      if (lane_start[i] || xor_mode) carry = 1'b0;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/p_mul_iter.sv
// p_mul_iter
// Iterative packed-SIMD multiplier (integer or carry-less). Each BUSY cycle
// retires BITS_PER_CYCLE multiplier bits in every lane; after
// ceil(W/BITS_PER_CYCLE) steps the low or high half of each lane product is
// registered into result and ready pulses for one cycle.
// Ports:
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   valid / ready : request held until the one-cycle ready pulse
//   mul_l / mul_h : select low (priority) or high half of each lane product
//   clmul         : 1 = carry-less multiply, 0 = unsigned integer multiply
//   pw            : one-hot pack width, pw[i] -> lane width XLEN>>i
//   crs1 / crs2   : packed multiplicand / multiplier
//   result        : registered packed result
module p_mul_iter
  import p_mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int PW_W           = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            valid,
  output logic            ready,
  input  logic            mul_l,
  input  logic            mul_h,
  input  logic            clmul,
  input  logic [PW_W-1:0] pw,
  input  logic [XLEN-1:0] crs1,
  input  logic [XLEN-1:0] crs2,
  output logic [XLEN-1:0] result
);

  localparam int AW    = 2 * XLEN;
  localparam int AW_IW = $clog2(AW);
  localparam int MP_IW = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN) + 2;

  state_t            state;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_next;
  logic [AW-1:0]     mcand;
  logic [AW-1:0]     mcand_init;
  logic [AW-1:0]     step_sum;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   res_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  bit_pos;
  logic [CNT_W-1:0]  lane_w;
  logic [PW_W-1:0]   pw_q;
  logic              clmul_q;
  logic              mul_l_q;
  logic              mul_h_q;
  logic              pw_ok_q;

  // Spread the packed multiplicand so lane k sits zero-extended at the bottom
  // of its 2W-bit accumulator slice: source bit b lands at 2b - (b mod W).
  always_comb begin
    int w;
    logic [AW_IW-1:0] idx;
    w          = lane_width(32'(pw), XLEN);
    mcand_init = '0;
    idx        = '0;
    if (w != 0) begin
      for (int b = 0; b < XLEN; b++) begin
        idx             = AW_IW'(2 * b - (b & (w - 1)));
        mcand_init[idx] = crs1[b];
      end
    end
  end

  // One step's partial products. mcand is already shifted by bit_pos, and
  // mplier is shifted right by bit_pos, so multiplier bit j of lane k sits at
  // mplier[kW + j]. Offsets at or beyond W are dropped, which both ignores
  // excess multiplier bits and keeps every shifted copy inside its slice, so
  // the in-step sum cannot spill into a neighbouring lane.
  always_comb begin
    int w;
    logic [AW-1:0]    shifted;
    logic [AW-1:0]    gate;
    logic [MP_IW-1:0] src;
    w        = int'(lane_w);
    step_sum = '0;
    shifted  = '0;
    gate     = '0;
    src      = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      shifted = mcand << j;
      gate    = '0;
      if (int'(bit_pos) + j < w) begin
        for (int d = 0; d < AW; d++) begin
          src     = MP_IW'(((d & ~(2 * w - 1)) >> 1) + j);
          gate[d] = mplier[src];
        end
      end
      if (clmul_q) step_sum = step_sum ^ (shifted & gate);
      else         step_sum = step_sum + (shifted & gate);
    end
  end

  p_mul_padd #(
    .XLEN (XLEN),
    .PW_W (PW_W)
  ) u_padd (
    .pw       (pw_q),
    .xor_mode (clmul_q),
    .a        (acc),
    .b        (step_sum),
    .sum      (acc_next)
  );

  // Gather the requested half of each lane product out of the post-step
  // accumulator: low half of lane k starts at 2kW, high half at 2kW + W.
  always_comb begin
    int w;
    logic [AW_IW-1:0] idx;
    w        = int'(lane_w);
    res_next = '0;
    idx      = '0;
    if (pw_ok_q && (mul_l_q || mul_h_q)) begin
      for (int b = 0; b < XLEN; b++) begin
        idx         = AW_IW'(2 * b - (b & (w - 1)) + (mul_l_q ? 0 : w));
        res_next[b] = acc_next[idx];
      end
    end
  end

  // Control FSM and datapath registers. Operands are latched at accept so
  // requester-side changes during BUSY have no effect; dropping valid while
  // BUSY abandons the operation without touching result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      ready   <= 1'b0;
      result  <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      bit_pos <= '0;
      lane_w  <= '0;
      pw_q    <= '0;
      clmul_q <= 1'b0;
      mul_l_q <= 1'b0;
      mul_h_q <= 1'b0;
      pw_ok_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready <= 1'b0;
          if (valid) begin
            acc     <= '0;
            mcand   <= mcand_init;
            mplier  <= crs2;
            pw_q    <= pw;
            clmul_q <= clmul;
            mul_l_q <= mul_l;
            mul_h_q <= mul_h;
            pw_ok_q <= pw_onehot(32'(pw));
            lane_w  <= CNT_W'(lane_width(32'(pw), XLEN));
            cnt     <= CNT_W'(step_count(32'(pw), XLEN, BITS_PER_CYCLE));
            bit_pos <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!valid) begin
            state <= ST_IDLE;
          end else begin
            acc     <= acc_next;
            mcand   <= mcand << BITS_PER_CYCLE;
            mplier  <= mplier >> BITS_PER_CYCLE;
            bit_pos <= bit_pos + CNT_W'(BITS_PER_CYCLE);
            cnt     <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              result <= res_next;
              ready  <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          ready <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/p_mul_iter.md
Name: p_mul_iter

Overview:
- Iterative packed-SIMD multiplier, the parametrised successor to the single-cycle packed multiply path.
- Supports every one-hot pack width from XLEN down to 2-bit lanes, in both integer and carry-less (clmul) modes.
- Consumes BITS_PER_CYCLE multiplier bits per lane per cycle, so area and latency can be traded.
- Sits in the crypto coprocessor execute stage behind the same valid/ready handshake as the other packed-arithmetic units.

Parameters:
- XLEN, 32, operand width; power of two, 32 or 64.
- BITS_PER_CYCLE, 1, multiplier bits retired per lane per step; 1, 2 or 4.
- PW_W, $clog2(XLEN), width of the one-hot pack-width select.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- valid  in  1  request; held high with stable inputs until ready.
- ready  out  1  one-cycle pulse; result valid in that cycle.
- mul_l  in  1  return low half of each lane product.
- mul_h  in  1  return high half of each lane product.
- clmul  in  1  1 = carry-less (XOR) multiply, 0 = unsigned integer multiply.
- pw  in  PW_W  one-hot pack width; pw[i] selects lane width W = XLEN>>i (XLEN=32: pw[0]=32, [1]=16, [2]=8, [3]=4, [4]=2).
- crs1  in  XLEN  multiplicand, packed.
- crs2  in  XLEN  multiplier, packed.
- result  out  XLEN  registered result.

Behaviour:
- Reset (async, resetn=0): state=IDLE, ready=0, result=0, accumulator and step counter cleared, immediately and asynchronously; this applies mid-operation too.
- States: IDLE, BUSY, DONE.
- IDLE, valid=1 at edge E0 (accept): latch crs1, crs2, pw, clmul, mul_l, mul_h; clear the 2*XLEN accumulator; load N = ceil(W/BITS_PER_CYCLE); go to BUSY.
- BUSY, each edge: for every lane, add (clmul: XOR) partial products of the next BITS_PER_CYCLE multiplier bits, shifted, into that lane's 2W-bit accumulator slice.
  - Carries never cross lane slices.
  - Multiplier bits beyond W in a lane are ignored.
  - Decrement N.
- On the edge where N reaches 0:
  - Load result from the post-step accumulator.
  - mul_l=1: result lane k = low W bits of lane-k product.
  - mul_l=0, mul_h=1: result lane k = high W bits of lane-k product.
  - Both low: result = 0. mul_l takes precedence.
  - Go to DONE.
- Latency: ready is high in the cycle following edge E0+N (pw32, BITS_PER_CYCLE=1: N=32; pw16: 16; pw8: 8; pw2: 2).
- DONE: ready=1 for exactly one cycle; next edge goes to IDLE. result holds until the next completion. A new request can be accepted at the edge after DONE (one IDLE bubble).
- Abort: valid=0 sampled in BUSY → IDLE at that edge; no ready pulse; result unchanged.
- Input changes while BUSY with valid=1 are ignored because operands are latched.
- pw not one-hot (including zero): N=1, result=0, normal ready pulse.
- Lane product is unsigned, width 2W; clmul product degree ≤ 2W-2, so the top bit is 0.
- ready is never high in IDLE or BUSY.

Decomposition:
- Shared package p_mul_pkg holds:
  - state encoding localparams (IDLE/BUSY/DONE);
  - pw bit-index constants;
  - a lane-width function W(pw);
  - a step-count function N(pw, BITS_PER_CYCLE).
- One sub-module: p_mul_padd, a 2*XLEN packed adder with a per-lane carry break selected by pw and an XOR mode for clmul. It is instantiated once in the step datapath.

Test Plan:
- XLEN=32, BITS_PER_CYCLE=1, pw=00001, mul_l, crs1=crs2=0xFFFFFFFF → result 0x00000001, ready 32 cycles after accept; same op with mul_h → 0xFFFFFFFE.
- pw=00010, crs1=0xFFFF0002, crs2=0xFFFF0007 → mul_l 0x0001000E, mul_h 0xFFFE0000, ready after 16 cycles.
- pw=00100, clmul=1, crs1=crs2=0x03030303 → mul_l 0x05050505, mul_h 0x00000000, ready after 8 cycles.
- Abort then narrow op:
  - pw32 request, valid dropped at cycle 5 → no ready pulse, IDLE next cycle.
  - Then pw=10000, crs1=crs2=0xFFFFFFFF, mul_l → 0x55555555 after 2 cycles; mul_h → 0xAAAAAAAA.
- resetn pulsed low during BUSY → ready=0 and result=0 asynchronously; the first op after release completes normally.
- Back-to-back:
  - valid held high with new operands after ready → next accept one cycle after DONE.
  - With BITS_PER_CYCLE=4, a pw32 op completes in 8 cycles.
  - Random 10k-op regression against a reference model across all pw/clmul/mul_l/mul_h combinations.
